// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the uart_dev transceiver and its RX core:
//   - DATA_BITS    : payload bits per frame (8N1 framing)
//   - LINE_IDLE    : idle level of the serial line (mark = 1)
//   - tx_state_t   : TX FSM encoding (IDLE, START, DATA, STOP, GUARD)
//   - rx_state_t   : RX FSM encoding (IDLE, START, DATA, STOP)
//   - calc_div()   : clocks per bit from CLK_HZ/BAUD, clamped to a minimum of 4
package uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_STOP  = 3'd3,
        TX_GUARD = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3
    } rx_state_t;

    // The RX start-bit check waits DIV/2 cycles, so anything below 4
    // would leave no room between the edge and the mid-bit sample.
    function automatic int calc_div(input int clk_hz, input int baud);
        int d;
        d = clk_hz / baud;
        return (d < 4) ? 4 : d;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core
// Receive half of the UART: 2-flop synchronizer, RX FSM and a one-byte
// hold register.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   rxd          : asynchronous serial input
//   take         : consumer takes rx_byte this cycle (clears byte_valid)
//   rx_byte      : held received byte
//   byte_valid   : rx_byte holds a byte not yet taken
//   overrun      : sticky, a held byte was overwritten before being taken
//   frame_err    : sticky, a stop bit was sampled low
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 take,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 byte_valid,
    output logic                 overrun,
    output logic                 frame_err
);

    localparam int CW = $clog2(DIV);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    logic                 sync1;
    logic                 sync2;
    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;

    // Two-flop synchronizer; reset to the idle level so reset release
    // never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= LINE_IDLE;
            sync2 <= LINE_IDLE;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
        end
    end

    // RX FSM plus hold register. The take clear comes first so that a byte
    // finishing in the same cycle as a delivery re-sets byte_valid without
    // counting as an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (take) begin
                byte_valid <= 1'b0;
            end
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (sync2 == 1'b0) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // High at mid start bit means a glitch, not a frame.
                        state   <= sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shift <= {sync2, shift[DATA_BITS-1:1]};
                        if (bit_idx == LAST_BIT) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (sync2) begin
                            rx_byte    <= shift;
                            byte_valid <= 1'b1;
                            if (byte_valid && !take) begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_dev.sv
// uart_dev
// Byte-level 8N1 UART transceiver sitting below the disk device controller.
// Ports:
//   clk, rst        : system clock, synchronous active-high reset
//   dev_enable      : upstream request active
//   dev_we          : 1 = transmit request, 0 = receive request
//   dev_data_out    : byte to transmit
//   dev_data_in     : last delivered received byte
//   dev_write_done  : one-cycle pulse, transmitted byte finished
//   dev_read_done   : one-cycle pulse, dev_data_in holds a new byte
//   uart_txd        : serial out, idle high
//   uart_rxd        : serial in, asynchronous
//   tx_busy         : TX FSM not idle
//   rx_overrun      : sticky, undelivered byte overwritten
//   rx_frame_err    : sticky, stop bit sampled low
module uart_dev
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dev_enable,
    input  logic                 dev_we,
    input  logic [DATA_BITS-1:0] dev_data_out,
    output logic [DATA_BITS-1:0] dev_data_in,
    output logic                 dev_write_done,
    output logic                 dev_read_done,
    output logic                 uart_txd,
    input  logic                 uart_rxd,
    output logic                 tx_busy,
    output logic                 rx_overrun,
    output logic                 rx_frame_err
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int CW  = $clog2(DIV);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] DONE_AT  = CW'(DIV - 2);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    tx_state_t            tx_state;
    logic [CW-1:0]        tx_cnt;
    logic [BW-1:0]        tx_bit;
    logic [DATA_BITS-1:0] tx_shift;

    logic [DATA_BITS-1:0] rx_byte;
    logic                 rx_valid;
    logic                 take;

    // TX FSM. uart_txd is registered and updated on the edge that enters
    // each bit, so each level lasts exactly DIV cycles. The done pulse is
    // launched one cycle early so it is visible during the last stop cycle;
    // GUARD then gives upstream a cycle to present the next byte before
    // IDLE samples again. Requests are only looked at in IDLE, so dropping
    // dev_enable/dev_we or changing dev_data_out mid-frame has no effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state       <= TX_IDLE;
            tx_cnt         <= '0;
            tx_bit         <= '0;
            tx_shift       <= '0;
            uart_txd       <= LINE_IDLE;
            dev_write_done <= 1'b0;
        end else begin
            dev_write_done <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt   <= '0;
                    uart_txd <= LINE_IDLE;
                    if (dev_enable && dev_we) begin
                        tx_shift <= dev_data_out;
                        uart_txd <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        uart_txd <= tx_shift[0];
                        tx_shift <= {1'b1, tx_shift[DATA_BITS-1:1]};
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == LAST_BIT) begin
                            uart_txd <= LINE_IDLE;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            uart_txd <= tx_shift[0];
                            tx_shift <= {1'b1, tx_shift[DATA_BITS-1:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == DONE_AT) begin
                        dev_write_done <= 1'b1;
                    end
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= TX_GUARD;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_GUARD: begin
                    tx_state <= TX_IDLE;
                end
                default: begin
                    tx_state <= TX_IDLE;
                    uart_txd <= LINE_IDLE;
                end
            endcase
        end
    end

    assign tx_busy = (tx_state != TX_IDLE);

    // A delivery is blocked in the cycle right after another one, which
    // keeps read_done pulses from ever running back to back.
    assign take = dev_enable && !dev_we && rx_valid && !dev_read_done;

    // Delivery register: dev_data_in only changes on a delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            dev_data_in   <= '0;
            dev_read_done <= 1'b0;
        end else begin
            dev_read_done <= take;
            if (take) begin
                dev_data_in <= rx_byte;
            end
        end
    end

    uart_rx_core #(
        .DIV (DIV)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rxd        (uart_rxd),
        .take       (take),
        .rx_byte    (rx_byte),
        .byte_valid (rx_valid),
        .overrun    (rx_overrun),
        .frame_err  (rx_frame_err)
    );

endmodule

// File: tb/tb_uart_dev.sv
// tb_uart_dev
// Self-checking bench for uart_dev with CLK_HZ=16, BAUD=1 (16 clocks/bit).
// A line-level monitor decodes frames seen on uart_txd and records
// read_done deliveries; each test task compares those against the bytes
// it sent.
module tb_uart_dev;

    localparam int DIV = 16;
    localparam int FRAME = 10 * DIV;

    logic       clk;
    logic       rst;
    logic       dev_enable;
    logic       dev_we;
    logic [7:0] dev_data_out;
    logic [7:0] dev_data_in;
    logic       dev_write_done;
    logic       dev_read_done;
    logic       uart_txd;
    logic       uart_rxd;
    logic       tx_busy;
    logic       rx_overrun;
    logic       rx_frame_err;

    int errors = 0;
    int checks = 0;

    // monitor state
    int         cyc_cnt = 0;
    int         wd_count = 0;
    logic [7:0] rd_q[$];
    int         rd_t[$];
    logic [8:0] tx_seen[$];
    bit         mon_active = 0;
    int         mon_rel = 0;
    logic [7:0] mon_bits;

    uart_dev #(
        .CLK_HZ (16),
        .BAUD   (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dev_enable     (dev_enable),
        .dev_we         (dev_we),
        .dev_data_out   (dev_data_out),
        .dev_data_in    (dev_data_in),
        .dev_write_done (dev_write_done),
        .dev_read_done  (dev_read_done),
        .uart_txd       (uart_txd),
        .uart_rxd       (uart_rxd),
        .tx_busy        (tx_busy),
        .rx_overrun     (rx_overrun),
        .rx_frame_err   (rx_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line-level observer: decodes 8N1 frames on uart_txd by mid-bit
    // sampling, counts write_done pulses and logs read_done deliveries.
    always @(negedge clk) begin
        cyc_cnt++;
        if (dev_read_done) begin
            rd_q.push_back(dev_data_in);
            rd_t.push_back(cyc_cnt);
        end
        if (dev_write_done) wd_count++;
        if (rst) begin
            mon_active = 0;
        end else if (!mon_active) begin
            if (uart_txd == 1'b0) begin
                mon_active = 1;
                mon_rel = 0;
            end
        end else begin
            mon_rel++;
            if (mon_rel >= DIV && mon_rel < 9 * DIV && (mon_rel % DIV) == DIV / 2)
                mon_bits[mon_rel / DIV - 1] = uart_txd;
            if (mon_rel == 9 * DIV + DIV / 2) begin
                tx_seen.push_back({uart_txd, mon_bits});
                mon_active = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dev_enable = 1'b0;
        dev_we = 1'b0;
        dev_data_out = 8'h00;
        uart_rxd = 1'b1;
        step();
        step();
        rst = 1'b0;
        rd_q.delete();
        rd_t.delete();
        tx_seen.delete();
        wd_count = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = f[i];
            repeat (DIV) step();
        end
        uart_rxd = 1'b1;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        do_reset();
        checks++; if (uart_txd !== 1'b1) begin errors++; $display("[TB] FAIL reset_txd: got %b expected 1", uart_txd); end
        checks++; if (dev_data_in !== 8'h00) begin errors++; $display("[TB] FAIL reset_data_in: got %h expected 00", dev_data_in); end
        checks++; if (dev_write_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_write_done: got %b expected 0", dev_write_done); end
        checks++; if (dev_read_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_read_done: got %b expected 0", dev_read_done); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_busy: got %b expected 0", tx_busy); end
        checks++; if (rx_overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", rx_overrun); end
        checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", rx_frame_err); end
    endtask

    // Cycle-exact TX waveform for 0xA5; n counts clock edges after the
    // edge that samples the request.
    task automatic test_tx_single();
        logic [9:0] frame;
        logic       exp_txd;
        $display("[TB] test_tx_single");
        do_reset();
        frame = {1'b1, 8'hA5, 1'b0};
        dev_data_out = 8'hA5;
        dev_enable = 1'b1;
        dev_we = 1'b1;
        for (int n = 0; n < 162; n++) begin
            step();
            exp_txd = (n < FRAME) ? frame[n / DIV] : 1'b1;
            checks++;
            if (uart_txd !== exp_txd) begin
                errors++;
                $display("[TB] FAIL tx_single_txd cycle %0d: got %b expected %b", n, uart_txd, exp_txd);
            end
            checks++;
            if (dev_write_done !== (n == FRAME - 1)) begin
                errors++;
                $display("[TB] FAIL tx_single_done cycle %0d: got %b expected %b", n, dev_write_done, (n == FRAME - 1));
            end
            if (n <= FRAME) begin
                checks++;
                if (tx_busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL tx_single_busy cycle %0d: got %b expected 1", n, tx_busy);
                end
            end
        end
        dev_enable = 1'b0;
        repeat (FRAME + 10) step();
    endtask

    // Upstream advances dev_data_out on each done pulse.
    task automatic test_back_to_back();
        logic [7:0] bytes[4];
        int         done_t[4];
        int         nd;
        $display("[TB] test_back_to_back");
        do_reset();
        bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        nd = 0;
        dev_data_out = bytes[0];
        dev_enable = 1'b1;
        dev_we = 1'b1;
        for (int c = 0; c < 4 * 162 + 60; c++) begin
            step();
            if (dev_write_done) begin
                if (nd < 4) done_t[nd] = c;
                nd++;
                if (nd < 4) dev_data_out = bytes[nd];
                else dev_enable = 1'b0;
            end
        end
        checks++;
        if (nd !== 4) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 4", nd); end
        if (nd >= 4) begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (done_t[i] - done_t[i-1] !== 162) begin
                    errors++;
                    $display("[TB] FAIL b2b_spacing %0d: got %0d expected 162", i, done_t[i] - done_t[i-1]);
                end
            end
        end
        checks++;
        if (tx_seen.size() !== 4) begin errors++; $display("[TB] FAIL b2b_frames: got %0d expected 4", tx_seen.size()); end
        for (int i = 0; i < 4 && i < tx_seen.size(); i++) begin
            checks++;
            if (tx_seen[i] !== {1'b1, bytes[i]}) begin
                errors++;
                $display("[TB] FAIL b2b_frame %0d: got %h expected %h", i, tx_seen[i], {1'b1, bytes[i]});
            end
        end
    endtask

    // Request lines and data churn randomly after the request is latched.
    task automatic test_tx_immunity();
        logic [7:0] b;
        $display("[TB] test_tx_immunity");
        for (int k = 0; k < 3; k++) begin
            do_reset();
            b = 8'($urandom);
            dev_data_out = b;
            dev_enable = 1'b1;
            dev_we = 1'b1;
            step();
            for (int n = 1; n < 175; n++) begin
                dev_data_out = 8'($urandom);
                dev_we = 1'($urandom);
                dev_enable = (n < 140) ? 1'($urandom) : 1'b0;
                step();
            end
            checks++;
            if (wd_count !== 1) begin errors++; $display("[TB] FAIL immunity_done_count: got %0d expected 1", wd_count); end
            checks++;
            if (tx_seen.size() !== 1 || tx_seen[0] !== {1'b1, b}) begin
                errors++;
                $display("[TB] FAIL immunity_frame: got %0d frames first %h expected %h", tx_seen.size(), (tx_seen.size() > 0) ? tx_seen[0] : 9'h0, {1'b1, b});
            end
        end
    endtask

    task automatic test_rx_single();
        int t0;
        $display("[TB] test_rx_single");
        do_reset();
        dev_enable = 1'b1;
        dev_we = 1'b0;
        t0 = cyc_cnt;
        send_frame(8'hFF, 1'b1);
        repeat (20) step();
        checks++;
        if (rd_q.size() !== 1) begin errors++; $display("[TB] FAIL rx_ff_pulses: got %0d expected 1", rd_q.size()); end
        if (rd_q.size() > 0) begin
            checks++;
            if (rd_q[0] !== 8'hFF) begin errors++; $display("[TB] FAIL rx_ff_data: got %h expected ff", rd_q[0]); end
            checks++;
            if (rd_t[0] - t0 > FRAME + 4) begin
                errors++;
                $display("[TB] FAIL rx_ff_latency: got %0d expected <= %0d", rd_t[0] - t0, FRAME + 4);
            end
        end
        checks++;
        if (dev_data_in !== 8'hFF) begin errors++; $display("[TB] FAIL rx_ff_hold: got %h expected ff", dev_data_in); end
    endtask

    task automatic test_rx_overrun();
        $display("[TB] test_rx_overrun");
        do_reset();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (10) step();
        checks++;
        if (rd_q.size() !== 0) begin errors++; $display("[TB] FAIL overrun_early_pulse: got %0d expected 0", rd_q.size()); end
        checks++;
        if (rx_overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_flag: got %b expected 1", rx_overrun); end
        dev_enable = 1'b1;
        dev_we = 1'b0;
        step();
        checks++;
        if (dev_read_done !== 1'b1) begin errors++; $display("[TB] FAIL overrun_arm_pulse: got %b expected 1", dev_read_done); end
        checks++;
        if (dev_data_in !== 8'h22) begin errors++; $display("[TB] FAIL overrun_data: got %h expected 22", dev_data_in); end
        repeat (20) step();
        checks++;
        if (rd_q.size() !== 1) begin errors++; $display("[TB] FAIL overrun_pulse_count: got %0d expected 1", rd_q.size()); end
        checks++;
        if (rx_frame_err !== 1'b0) begin errors++; $display("[TB] FAIL overrun_frame_err: got %b expected 0", rx_frame_err); end
    endtask

    task automatic test_rx_errors();
        $display("[TB] test_rx_errors");
        do_reset();
        dev_enable = 1'b1;
        dev_we = 1'b0;
        uart_rxd = 1'b0;
        repeat (4) step();
        uart_rxd = 1'b1;
        repeat (40) step();
        checks++;
        if (rd_q.size() !== 0) begin errors++; $display("[TB] FAIL glitch_pulse: got %0d expected 0", rd_q.size()); end
        checks++;
        if (rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_flags: got fe=%b ov=%b expected 0 0", rx_frame_err, rx_overrun);
        end
        send_frame(8'h5A, 1'b0);
        repeat (40) step();
        checks++;
        if (rx_frame_err !== 1'b1) begin errors++; $display("[TB] FAIL framing_flag: got %b expected 1", rx_frame_err); end
        checks++;
        if (rd_q.size() !== 0) begin errors++; $display("[TB] FAIL framing_pulse: got %0d expected 0", rd_q.size()); end
        checks++;
        if (rx_overrun !== 1'b0) begin errors++; $display("[TB] FAIL framing_overrun: got %b expected 0", rx_overrun); end
    endtask

    task automatic test_rx_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        $display("[TB] test_rx_random");
        do_reset();
        dev_enable = 1'b1;
        dev_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1);
        end
        repeat (30) step();
        checks++;
        if (rd_q.size() !== 4) begin errors++; $display("[TB] FAIL rx_rand_count: got %0d expected 4", rd_q.size()); end
        for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
            checks++;
            if (rd_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rx_rand_byte %0d: got %h expected %h", i, rd_q[i], exp_q[i]); end
            if (i > 0) begin
                checks++;
                if (rd_t[i] - rd_t[i-1] < 2) begin
                    errors++;
                    $display("[TB] FAIL rx_rand_gap %0d: got %0d expected >= 2", i, rd_t[i] - rd_t[i-1]);
                end
            end
        end
        checks++;
        if (rx_overrun !== 1'b0) begin errors++; $display("[TB] FAIL rx_rand_overrun: got %b expected 0", rx_overrun); end
    endtask

    task automatic test_full_duplex();
        logic [7:0] tb_byte;
        logic [7:0] rb_byte;
        $display("[TB] test_full_duplex");
        do_reset();
        tb_byte = 8'($urandom);
        rb_byte = 8'($urandom);
        fork
            send_frame(rb_byte, 1'b1);
            begin
                dev_data_out = tb_byte;
                dev_enable = 1'b1;
                dev_we = 1'b1;
                step();
                dev_we = 1'b0;
            end
        join
        repeat (30) step();
        checks++;
        if (tx_seen.size() !== 1 || tx_seen[0] !== {1'b1, tb_byte}) begin
            errors++;
            $display("[TB] FAIL duplex_tx: got %0d frames first %h expected %h", tx_seen.size(), (tx_seen.size() > 0) ? tx_seen[0] : 9'h0, {1'b1, tb_byte});
        end
        checks++;
        if (wd_count !== 1) begin errors++; $display("[TB] FAIL duplex_done_count: got %0d expected 1", wd_count); end
        checks++;
        if (rd_q.size() !== 1 || dev_data_in !== rb_byte) begin
            errors++;
            $display("[TB] FAIL duplex_rx: got %0d pulses data %h expected 1 pulse data %h", rd_q.size(), dev_data_in, rb_byte);
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [7:0] b;
        $display("[TB] test_reset_mid_tx");
        do_reset();
        dev_data_out = 8'($urandom);
        dev_enable = 1'b1;
        dev_we = 1'b1;
        step();
        dev_enable = 1'b0;
        repeat (49) step();
        rst = 1'b1;
        step();
        checks++;
        if (uart_txd !== 1'b1) begin errors++; $display("[TB] FAIL midrst_txd: got %b expected 1", uart_txd); end
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", tx_busy); end
        rst = 1'b0;
        repeat (200) step();
        checks++;
        if (wd_count !== 0) begin errors++; $display("[TB] FAIL midrst_no_done: got %0d expected 0", wd_count); end
        checks++;
        if (tx_seen.size() !== 0) begin errors++; $display("[TB] FAIL midrst_no_frame: got %0d expected 0", tx_seen.size()); end
        b = 8'($urandom);
        dev_data_out = b;
        dev_enable = 1'b1;
        dev_we = 1'b1;
        step();
        dev_enable = 1'b0;
        repeat (175) step();
        checks++;
        if (tx_seen.size() !== 1 || tx_seen[0] !== {1'b1, b}) begin
            errors++;
            $display("[TB] FAIL midrst_retx: got %0d frames first %h expected %h", tx_seen.size(), (tx_seen.size() > 0) ? tx_seen[0] : 9'h0, {1'b1, b});
        end
        checks++;
        if (wd_count !== 1) begin errors++; $display("[TB] FAIL midrst_retx_done: got %0d expected 1", wd_count); end
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_tx_immunity();
        test_rx_single();
        test_rx_overrun();
        test_rx_errors();
        test_rx_random();
        test_full_duplex();
        test_reset_mid_tx();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
